// File: rtl/am2951_mbox_if.sv
// Handshake, flag and control signals between the am2951 mailbox controller,
// its two bus requesters and the am2951 register pair.
interface am2951_mbox_if;
  logic wr_a_req, wr_a_ack, rd_a_req, rd_a_ack;
  logic wr_b_req, wr_b_ack, rd_b_req, rd_b_ack;
  logic fr, fs;
  logic cpr, cer_, clrr, cps, ces_, clrs;
  logic oea_, oeb_;
  logic irq_b, irq_a, err;

  modport slave (
    input  wr_a_req, rd_a_req, wr_b_req, rd_b_req, fr, fs,
    output wr_a_ack, rd_a_ack, wr_b_ack, rd_b_ack,
           cpr, cer_, clrr, cps, ces_, clrs, oea_, oeb_, irq_b, irq_a, err
  );

  modport master (
    output wr_a_req, rd_a_req, wr_b_req, rd_b_req, fr, fs,
    input  wr_a_ack, rd_a_ack, wr_b_ack, rd_b_ack,
           cpr, cer_, clrr, cps, ces_, clrs, oea_, oeb_, irq_b, irq_a, err
  );
endinterface

// File: rtl/am2951_mbox_ctl.sv
// am2951 two-way mailbox sequencer: one load/read FSM per bus, shared
// full-shadow state, and a sticky check of the am2951 fr/fs flags.
module am2951_mbox_bus #(
  parameter int RD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_req,
  input  logic rd_req,
  input  logic wr_ok,
  input  logic rd_ok,
  output logic ld,
  output logic ld_clk,
  output logic wr_ack,
  output logic rd_oe,
  output logic rd_ack,
  output logic clr
);
  typedef enum logic [2:0] {IDLE, LD1, LD2, RD, CLR} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       wr_first, wr_first_nxt;
  logic       wr_go, rd_go;

  assign wr_go = wr_req & wr_ok;
  assign rd_go = rd_req & rd_ok;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd1;
      wr_first <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wr_first <= wr_first_nxt;
    end
  end

  always_comb begin
    // NOTE: every output is defaulted first so no path through the case infers a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    wr_first_nxt = wr_first;
    ld           = 1'b0;
    ld_clk       = 1'b0;
    wr_ack       = 1'b0;
    rd_oe        = 1'b0;
    rd_ack       = 1'b0;
    clr          = 1'b0;
    case (state)
      IDLE: begin
        // The pointer only swings when it actually resolved a contention.
        if (wr_go && rd_go) begin
          if (wr_first) begin
            state_nxt = LD1;
          end else begin
            state_nxt = RD;
            cnt_nxt   = 4'd1;
          end
          wr_first_nxt = ~wr_first;
        end else if (wr_go) begin
          state_nxt = LD1;
        end else if (rd_go) begin
          state_nxt = RD;
          cnt_nxt   = 4'd1;
        end
      end
      LD1: begin
        ld        = 1'b1;
        state_nxt = LD2;
      end
      LD2: begin
        ld        = 1'b1;
        ld_clk    = 1'b1;
        wr_ack    = 1'b1;
        state_nxt = IDLE;
      end
      RD: begin
        rd_oe = 1'b1;
        if (cnt == 4'(RD_CYCLES)) begin
          rd_ack    = 1'b1;
          state_nxt = CLR;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      CLR: begin
        clr       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

module am2951_mbox_ctl #(
  parameter int RD_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  am2951_mbox_if.slave mb
);
  logic r_full, s_full, err_q, quiet_q;
  logic a_ld, a_ld_clk, a_wr_ack, a_rd_oe, a_rd_ack, a_clr;
  logic b_ld, b_ld_clk, b_wr_ack, b_rd_oe, b_rd_ack, b_clr;

  // Bus A loads R and reads S; bus B loads S and reads R.
  am2951_mbox_bus #(.RD_CYCLES(RD_CYCLES)) u_bus_a (
    .clk(clk), .rst(rst),
    .wr_req(mb.wr_a_req), .rd_req(mb.rd_a_req),
    .wr_ok(~r_full), .rd_ok(s_full),
    .ld(a_ld), .ld_clk(a_ld_clk), .wr_ack(a_wr_ack),
    .rd_oe(a_rd_oe), .rd_ack(a_rd_ack), .clr(a_clr)
  );

  am2951_mbox_bus #(.RD_CYCLES(RD_CYCLES)) u_bus_b (
    .clk(clk), .rst(rst),
    .wr_req(mb.wr_b_req), .rd_req(mb.rd_b_req),
    .wr_ok(~s_full), .rd_ok(r_full),
    .ld(b_ld), .ld_clk(b_ld_clk), .wr_ack(b_wr_ack),
    .rd_oe(b_rd_oe), .rd_ack(b_rd_ack), .clr(b_clr)
  );

  // Reset overrides the decoded controls immediately, before the FSMs settle.
  assign mb.cpr      = ~rst & a_ld_clk;
  assign mb.cer_     =  rst | ~a_ld;
  assign mb.clrs     =  rst | a_clr;
  assign mb.oea_     =  rst | ~a_rd_oe;
  assign mb.wr_a_ack = ~rst & a_wr_ack;
  assign mb.rd_a_ack = ~rst & a_rd_ack;
  assign mb.cps      = ~rst & b_ld_clk;
  assign mb.ces_     =  rst | ~b_ld;
  assign mb.clrr     =  rst | b_clr;
  assign mb.oeb_     =  rst | ~b_rd_oe;
  assign mb.wr_b_ack = ~rst & b_wr_ack;
  assign mb.rd_b_ack = ~rst & b_rd_ack;
  assign mb.irq_b    = ~rst & r_full;
  assign mb.irq_a    = ~rst & s_full;
  assign mb.err      = ~rst & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      s_full  <= 1'b0;
      err_q   <= 1'b0;
      quiet_q <= 1'b0;
    end else begin
      if (a_ld_clk)   r_full <= 1'b1;
      else if (b_clr) r_full <= 1'b0;
      if (b_ld_clk)   s_full <= 1'b1;
      else if (a_clr) s_full <= 1'b0;
      // Flags are only trusted one full cycle after any clock or clear pulse.
      quiet_q <= ~(a_ld_clk | b_ld_clk | a_clr | b_clr);
      if (quiet_q && ((mb.fr != r_full) || (mb.fs != s_full))) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_am2951_mbox_ctl.sv
// Self-checking bench for am2951_mbox_ctl: directed scenarios then random
// traffic, compared cycle by cycle against a transaction-timeline model.
module tb_am2951_mbox_ctl;
  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst;
  logic fr_dev = 1'b0, fs_dev = 1'b0;
  logic fr_inj, fs_inj;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  am2951_mbox_if mb();

  am2951_mbox_ctl #(.RD_CYCLES(RD)) dut (
    .clk(clk),
    .rst(rst),
    .mb (mb)
  );

  // Attached am2951 flag behaviour plus an injection hook for flag faults.
  always @(posedge clk) begin
    if (mb.clrr)     fr_dev <= 1'b0;
    else if (mb.cpr) fr_dev <= 1'b1;
    if (mb.clrs)     fs_dev <= 1'b0;
    else if (mb.cps) fs_dev <= 1'b1;
  end
  assign mb.fr = fr_dev ^ fr_inj;
  assign mb.fs = fs_dev ^ fs_inj;

  // Model: per bus an operation (0 none, 1 load, 2 read) and cycles since grant.
  int m_op_a = 0, m_t_a = 0, m_op_b = 0, m_t_b = 0;
  bit m_ptr_a = 1'b1, m_ptr_b = 1'b1;
  bit m_rfull = 1'b0, m_sfull = 1'b0, m_err = 1'b0, m_quiet = 1'b0;
  logic seen_wa = 1'b0, seen_ra = 1'b0, seen_wb = 1'b0, seen_rb = 1'b0;

  function automatic bit ld_on(int op);          return op == 1;               endfunction
  function automatic bit ld_pulse(int op, int t); return op == 1 && t == 2;     endfunction
  function automatic bit rd_on(int op, int t);    return op == 2 && t <= RD;    endfunction
  function automatic bit rd_last(int op, int t);  return op == 2 && t == RD;    endfunction
  function automatic bit clr_on(int op, int t);   return op == 2 && t == RD + 1; endfunction

  function automatic logic [14:0] model_out();
    if (rst)
      return {4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000};
    return {ld_pulse(m_op_a, m_t_a), rd_last(m_op_a, m_t_a),
            ld_pulse(m_op_b, m_t_b), rd_last(m_op_b, m_t_b),
            ld_pulse(m_op_a, m_t_a), !ld_on(m_op_a), clr_on(m_op_b, m_t_b),
            ld_pulse(m_op_b, m_t_b), !ld_on(m_op_b), clr_on(m_op_a, m_t_a),
            !rd_on(m_op_a, m_t_a), !rd_on(m_op_b, m_t_b),
            m_rfull, m_sfull, m_err};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {mb.wr_a_ack, mb.rd_a_ack, mb.wr_b_ack, mb.rd_b_ack,
            mb.cpr, mb.cer_, mb.clrr, mb.cps, mb.ces_, mb.clrs,
            mb.oea_, mb.oeb_, mb.irq_b, mb.irq_a, mb.err};
  endfunction

  task automatic bus_step(inout int op, inout int t, inout bit ptr, input bit wr_ok, input bit rd_ok);
    if (op != 0) begin
      t++;
      if ((op == 1 && t > 2) || (op == 2 && t > RD + 1)) begin
        op = 0;
        t  = 0;
      end
    end else if (wr_ok && rd_ok) begin
      op  = ptr ? 1 : 2;
      t   = 1;
      ptr = !ptr;
    end else if (wr_ok) begin
      op = 1;
      t  = 1;
    end else if (rd_ok) begin
      op = 2;
      t  = 1;
    end
  endtask

  task automatic model_step();
    bit p_cpr, p_cps, p_clrr, p_clrs, a_wr, a_rd, b_wr, b_rd;
    if (rst) begin
      m_op_a = 0; m_t_a = 0; m_op_b = 0; m_t_b = 0;
      m_ptr_a = 1'b1; m_ptr_b = 1'b1;
      m_rfull = 1'b0; m_sfull = 1'b0; m_err = 1'b0; m_quiet = 1'b0;
      return;
    end
    p_cpr  = ld_pulse(m_op_a, m_t_a);
    p_cps  = ld_pulse(m_op_b, m_t_b);
    p_clrs = clr_on(m_op_a, m_t_a);
    p_clrr = clr_on(m_op_b, m_t_b);
    if (m_quiet && ((mb.fr !== m_rfull) || (mb.fs !== m_sfull))) m_err = 1'b1;
    m_quiet = !(p_cpr || p_cps || p_clrr || p_clrs);
    a_wr = mb.wr_a_req && !m_rfull;
    a_rd = mb.rd_a_req && m_sfull;
    b_wr = mb.wr_b_req && !m_sfull;
    b_rd = mb.rd_b_req && m_rfull;
    if (p_cpr)       m_rfull = 1'b1;
    else if (p_clrr) m_rfull = 1'b0;
    if (p_cps)       m_sfull = 1'b1;
    else if (p_clrs) m_sfull = 1'b0;
    bus_step(m_op_a, m_t_a, m_ptr_a, a_wr, a_rd);
    bus_step(m_op_b, m_t_b, m_ptr_b, b_wr, b_rd);
  endtask

  task automatic chk(string tag, logic [14:0] got, logic [14:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b expected=%b (ackWRa,RDa,WRb,RDb cpr cer_ clrr cps ces_ clrs oea_ oeb_ irq_b irq_a err)",
             tag, got, exp);
    end
  endtask

  task automatic chk1(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Inputs are already driven at the falling edge; check, advance model, wait a cycle.
  task automatic cycle(string tag);
    #1;
    chk(tag, dut_vec(), model_out());
    chk1({tag, "_oea_cer"}, !(mb.oea_ === 1'b0 && mb.cer_ === 1'b0), 1'b1);
    chk1({tag, "_oeb_ces"}, !(mb.oeb_ === 1'b0 && mb.ces_ === 1'b0), 1'b1);
    seen_wa = mb.wr_a_ack; seen_ra = mb.rd_a_ack;
    seen_wb = mb.wr_b_ack; seen_rb = mb.rd_b_ack;
    model_step();
    @(negedge clk);
  endtask

  function automatic logic next_req(logic cur, logic acked);
    if (acked) return 1'b0;
    if (!cur)  return $urandom_range(0, 3) == 0;
    return $urandom_range(0, 15) != 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mb.wr_a_req = 1'b0; mb.rd_a_req = 1'b0; mb.wr_b_req = 1'b0; mb.rd_b_req = 1'b0;
    cycle("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fr_inj = 1'b0; fs_inj = 1'b0;
    mb.wr_a_req = 1'b0; mb.rd_a_req = 1'b0; mb.wr_b_req = 1'b0; mb.rd_b_req = 1'b0;
    @(negedge clk);

    // Reset held two cycles.
    cycle("t1_rst");
    cycle("t1_rst");
    chk1("t1_clrr", mb.clrr, 1'b1);
    chk1("t1_clrs", mb.clrs, 1'b1);
    chk1("t1_cer", mb.cer_, 1'b1);
    rst = 1'b0;
    cycle("t1_idle");
    chk1("t1_fr", mb.fr, 1'b0);
    chk1("t1_fs", mb.fs, 1'b0);

    // A writes R, B reads it back.
    mb.wr_a_req = 1'b1;
    cycle("t2_grant");
    chk1("t2_ld1_cer", mb.cer_, 1'b0);
    chk1("t2_ld1_cpr", mb.cpr, 1'b0);
    cycle("t2_ld1");
    chk1("t2_ld2_cpr", mb.cpr, 1'b1);
    chk1("t2_ld2_ack", mb.wr_a_ack, 1'b1);
    cycle("t2_ld2");
    mb.wr_a_req = 1'b0;
    chk1("t2_irq_b", mb.irq_b, 1'b1);
    mb.rd_b_req = 1'b1;
    cycle("t2_rgrant");
    chk1("t2_rd1_oeb", mb.oeb_, 1'b0);
    chk1("t2_rd1_ack", mb.rd_b_ack, 1'b0);
    cycle("t2_rd1");
    chk1("t2_rd2_ack", mb.rd_b_ack, 1'b1);
    cycle("t2_rd2");
    mb.rd_b_req = 1'b0;
    chk1("t2_clrr", mb.clrr, 1'b1);
    chk1("t2_clr_oeb", mb.oeb_, 1'b1);
    cycle("t2_clr");
    chk1("t2_irq_b0", mb.irq_b, 1'b0);
    chk1("t2_err", mb.err, 1'b0);

    // Second write to a full R waits until B has drained it.
    mb.wr_a_req = 1'b1;
    cycle("t3_grant");
    cycle("t3_ld1");
    cycle("t3_ld2");
    for (int i = 0; i < 4; i++) begin
      chk1("t3_wait_cer", mb.cer_, 1'b1);
      chk1("t3_wait_ack", mb.wr_a_ack, 1'b0);
      cycle("t3_wait");
    end
    mb.rd_b_req = 1'b1;
    cycle("t3_rgrant");
    cycle("t3_rd1");
    mb.rd_b_req = 1'b0;
    chk1("t3_wait_cer2", mb.cer_, 1'b1);
    cycle("t3_rd2");
    chk1("t3_clr_cer", mb.cer_, 1'b1);
    cycle("t3_clr");
    cycle("t3_regrant");
    chk1("t3_ld1_cer", mb.cer_, 1'b0);
    cycle("t3_ld1b");
    chk1("t3_ld2_ack", mb.wr_a_ack, 1'b1);
    cycle("t3_ld2b");
    mb.wr_a_req = 1'b0;
    cycle("t3_end");

    // Bus A contention with S full and R empty: write wins first.
    do_reset();
    mb.wr_b_req = 1'b1;
    cycle("t4_sgrant");
    cycle("t4_sld1");
    cycle("t4_sld2");
    mb.wr_b_req = 1'b0;
    mb.wr_a_req = 1'b1;
    mb.rd_a_req = 1'b1;
    cycle("t4_grant");
    chk1("t4_ld1_cer", mb.cer_, 1'b0);
    chk1("t4_ld1_oea", mb.oea_, 1'b1);
    cycle("t4_ld1");
    chk1("t4_ld2_ack", mb.wr_a_ack, 1'b1);
    cycle("t4_ld2");
    mb.wr_a_req = 1'b0;
    cycle("t4_idle");
    chk1("t4_rd1_oea", mb.oea_, 1'b0);
    chk1("t4_rd1_cer", mb.cer_, 1'b1);
    cycle("t4_rd1");
    chk1("t4_rd2_ack", mb.rd_a_ack, 1'b1);
    cycle("t4_rd2");
    mb.rd_a_req = 1'b0;
    chk1("t4_clrs", mb.clrs, 1'b1);
    cycle("t4_clr");
    chk1("t4_irq_a0", mb.irq_a, 1'b0);

    // Both buses load concurrently.
    do_reset();
    mb.wr_a_req = 1'b1;
    mb.wr_b_req = 1'b1;
    cycle("t5_grant");
    cycle("t5_ld1");
    chk1("t5_cpr", mb.cpr, 1'b1);
    chk1("t5_cps", mb.cps, 1'b1);
    chk1("t5_ack_a", mb.wr_a_ack, 1'b1);
    chk1("t5_ack_b", mb.wr_b_ack, 1'b1);
    cycle("t5_ld2");
    mb.wr_a_req = 1'b0;
    mb.wr_b_req = 1'b0;
    chk1("t5_irq_a", mb.irq_a, 1'b1);
    chk1("t5_irq_b", mb.irq_b, 1'b1);
    cycle("t5_end");

    // Flag mismatch is sticky until reset.
    do_reset();
    cycle("t6_idle");
    fr_inj = 1'b1;
    cycle("t6_inj");
    fr_inj = 1'b0;
    chk1("t6_err", mb.err, 1'b1);
    mb.wr_a_req = 1'b1;
    cycle("t6_grant");
    cycle("t6_ld1");
    cycle("t6_ld2");
    mb.wr_a_req = 1'b0;
    cycle("t6_idle2");
    chk1("t6_err_sticky", mb.err, 1'b1);
    rst = 1'b1;
    cycle("t6_rst");
    chk1("t6_err_clr", mb.err, 1'b0);
    rst = 1'b0;
    cycle("t6_after");

    // Random traffic with occasional mid-operation resets and flag faults.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      mb.wr_a_req = next_req(mb.wr_a_req, seen_wa);
      mb.rd_a_req = next_req(mb.rd_a_req, seen_ra);
      mb.wr_b_req = next_req(mb.wr_b_req, seen_wb);
      mb.rd_b_req = next_req(mb.rd_b_req, seen_rb);
      fr_inj      = ($urandom_range(0, 299) == 0);
      fs_inj      = ($urandom_range(0, 299) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
